circ_queue: RTL and testbench

CIRC_QUEUE -- requirements
Module: circ_queue

---
 rtl/cq_pkg.sv | 17 +
 rtl/cq_ptr.sv | 25 ++
 rtl/circ_queue.sv | 116 +++++++++++
 tb/tb_circ_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cq_pkg.sv
// Shared constants and types for the circular queue.
package cq_pkg;

  localparam int unsigned CQ_DATA_W = 16;
  localparam int unsigned CQ_DEPTH  = 8;
  localparam int unsigned CQ_PTR_W  = $clog2(CQ_DEPTH);
  localparam int unsigned CQ_CNT_W  = CQ_PTR_W + 1;

  // Accepted-operation code: bit 1 = push accepted, bit 0 = pop accepted.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } cq_op_e;

endpackage

// File: rtl/cq_ptr.sv
// Wrapping pointer counter: advances by one on inc, wraps at 2**W.
module cq_ptr #(
  parameter int unsigned W = cq_pkg::CQ_PTR_W
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] PtrOne = W'(1);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + PtrOne;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/circ_queue.sv
// Circular queue with show-ahead output and count-based full/empty.
// Optional sticky error flag enabled by defining CIRC_QUEUE_ERR_EN.
module circ_queue
  import cq_pkg::*;
#(
  parameter int unsigned DATA_W = CQ_DATA_W,
  parameter int unsigned DEPTH  = CQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
`ifdef CIRC_QUEUE_ERR_EN
  input  logic                         err_clr,
  output logic                         err,
`endif
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_d;
  logic [PTR_W-1:0]  w_wptr;
  logic [PTR_W-1:0]  w_rptr;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [DEPTH-1:0]  w_we;
  cq_op_e            w_op;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign full      = (r_count == CntFull);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign w_op      = cq_op_e'({w_push_ok, w_pop_ok});

  cq_ptr #(
    .W (PTR_W)
  ) u_wptr (
    .clk    (clk),
    .reset_ (reset_),
    .inc    (w_push_ok),
    .ptr    (w_wptr)
  );

  cq_ptr #(
    .W (PTR_W)
  ) u_rptr (
    .clk    (clk),
    .reset_ (reset_),
    .inc    (w_pop_ok),
    .ptr    (w_rptr)
  );

  always_comb begin
    w_count_d = r_count;
    unique case (w_op)
      OpPush:  w_count_d = r_count + CntOne;
      OpPop:   w_count_d = r_count - CntOne;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  always_comb begin
    w_we = '0;
    if (w_push_ok) begin
      w_we[w_wptr] = 1'b1;
    end
  end

  // Storage is deliberately not reset; reset only discards entries via the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_we[i]) begin
        r_mem[i] <= din;
      end
    end
  end

  assign dout = r_mem[w_rptr];

`ifdef CIRC_QUEUE_ERR_EN
  logic r_err;

  // A rejected access sets the flag and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_err <= 1'b0;
    end else if ((push && full) || (pop && empty)) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_circ_queue.sv
// Self-checking bench for circ_queue: vector table, corner sequences, random vs queue model.
module tb_circ_queue;

  logic        clk = 1'b0;
  logic        reset_;
  logic        push;
  logic        pop;
  logic [15:0] din;
  logic [15:0] dout;
  logic        full;
  logic        empty;
  logic [3:0]  count;
`ifdef CIRC_QUEUE_ERR_EN
  logic        err;
  logic        err_clr;
`endif

  int total = 0;
  int bad   = 0;

  circ_queue #(
    .DATA_W (16),
    .DEPTH  (8)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
`ifdef CIRC_QUEUE_ERR_EN
    .err_clr (err_clr),
    .err     (err),
`endif
    .count   (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic        o;
    logic [15:0] d;
    logic [3:0]  cnt;
    logic        e;
    logic        f;
    logic        chk_q;
    logic [15:0] q;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic p, input logic o, input int d, input int cnt,
                              input logic chk_q, input int q, input logic er);
    vec_t v;
    v.p     = p;
    v.o     = o;
    v.d     = 16'(d);
    v.cnt   = 4'(cnt);
    v.e     = (cnt == 0);
    v.f     = (cnt == 8);
    v.chk_q = chk_q;
    v.q     = 16'(q);
    v.er    = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later.
  task automatic cyc(input logic p, input logic o, input logic [15:0] d);
    push = p;
    pop  = o;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset_ = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int          q[$];
  logic        rp, ro;
  logic [15:0] rd;
  bit          pok, ook;
`ifdef CIRC_QUEUE_ERR_EN
  logic        rc;
  logic        m_err;
`endif

  initial begin
    reset_ = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    din    = '0;
`ifdef CIRC_QUEUE_ERR_EN
    err_clr = 1'b0;
`endif
    #1;
    chk("init_count", 32'(count), 0);
    chk("init_empty", 32'(empty), 1);
    chk("init_full", 32'(full), 0);
`ifdef CIRC_QUEUE_ERR_EN
    chk("init_err", 32'(err), 0);
`endif
    #11;
    reset_ = 1'b1;
    @(posedge clk);
    #1;

    // Fill, overflow, drain, underflow, then simultaneous push+pop at empty and mid-level.
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 0, i, i, 1, 1, 0));
    tbl.push_back(mk(1, 0, 9, 8, 1, 1, 1));
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(0, 1, 0, 8 - k, 1, k + 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 'h55, 1, 1, 'h55, 1));
    tbl.push_back(mk(1, 0, 'h56, 2, 1, 'h55, 1));
    tbl.push_back(mk(1, 0, 'h57, 3, 1, 'h55, 1));
    tbl.push_back(mk(1, 1, 'h58, 3, 1, 'h56, 1));

    foreach (tbl[i]) begin
      cyc(tbl[i].p, tbl[i].o, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].f));
      if (tbl[i].chk_q) chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].q));
`ifdef CIRC_QUEUE_ERR_EN
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
`endif
    end

    // Asynchronous reset with five entries stored.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'(i + 'h30));
    chk("mid_count5", 32'(count), 5);
    do_reset();
`ifdef CIRC_QUEUE_ERR_EN
    chk("mid_err", 32'(err), 0);
`endif

    // Wrap: pointers at 6, then seven pushes cross 7 -> 0.
    for (int i = 0; i < 6; i++) cyc(1, 0, 16'(i + 'h100));
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    chk("wrap_empty", 32'(empty), 1);
    for (int i = 'hA; i <= 'h10; i++) cyc(1, 0, 16'(i));
    chk("wrap_count", 32'(count), 7);
    for (int i = 'hA; i <= 'h10; i++) begin
      chk($sformatf("wrap_dout_%0h", i), 32'(dout), 32'(i));
      cyc(0, 1, 0);
    end
    chk("wrap_drained", 32'(empty), 1);

    // Push+pop at full: only the pop is taken.
    for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(i + 'h20));
    chk("fb_full", 32'(full), 1);
    cyc(1, 1, 16'h0099);
    chk("fb_count", 32'(count), 7);
    chk("fb_head", 32'(dout), 'h22);
`ifdef CIRC_QUEUE_ERR_EN
    err_clr = 1'b1;
    cyc(0, 0, 0);
    err_clr = 1'b0;
    chk("clr_err", 32'(err), 0);
`endif
    cyc(1, 0, 16'h00AA);
    chk("fb_refull", 32'(full), 1);
`ifdef CIRC_QUEUE_ERR_EN
    chk("refull_err", 32'(err), 0);
    err_clr = 1'b1;
    cyc(1, 0, 16'h00BB);
    err_clr = 1'b0;
    chk("setclr_err", 32'(err), 1);
`else
    cyc(1, 0, 16'h00BB);
`endif
    chk("fb_ovf_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fb_dout%0d", i), 32'(dout), (i < 7) ? 32'(i + 'h22) : 32'h00AA);
      cyc(0, 1, 0);
    end
    chk("fb_empty", 32'(empty), 1);

    // Random traffic against a plain FIFO model.
    do_reset();
    q.delete();
`ifdef CIRC_QUEUE_ERR_EN
    m_err = 1'b0;
`endif
    for (int n = 0; n < 400; n++) begin
      rp = ($urandom_range(0, 99) < 55);
      ro = ($urandom_range(0, 99) < 45);
      rd = 16'($urandom);
      pok = rp && (q.size() < 8);
      ook = ro && (q.size() > 0);
`ifdef CIRC_QUEUE_ERR_EN
      rc = ($urandom_range(0, 9) == 0);
      if ((rp && q.size() == 8) || (ro && q.size() == 0)) m_err = 1'b1;
      else if (rc) m_err = 1'b0;
      err_clr = rc;
`endif
      cyc(rp, ro, rd);
`ifdef CIRC_QUEUE_ERR_EN
      err_clr = 1'b0;
`endif
      if (ook) void'(q.pop_front());
      if (pok) q.push_back(int'(rd));
      chk($sformatf("rnd%0d_count", n), 32'(count), 32'(q.size()));
      chk($sformatf("rnd%0d_empty", n), 32'(empty), 32'(q.size() == 0));
      chk($sformatf("rnd%0d_full", n), 32'(full), 32'(q.size() == 8));
      if (q.size() > 0) chk($sformatf("rnd%0d_dout", n), 32'(dout), 32'(q[0]));
`ifdef CIRC_QUEUE_ERR_EN
      chk($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
